trk_code_car_nco: RTL and testbench
===================================

Name: trk_code_car_nco

Overview:
- Tracking-channel NCO pair: the consumer of the loop-filter frequency control words (tx_prn_fcw, tx_car_fcw).
- Generates the local carrier phase, the code chip index and fractional code phase for the correlators.
- Emits the one-cycle code-period epoch pulse rx_prn_sop that drives the discriminator and loop-filter update.
- New FCWs are applied only at epoch boundaries, so each integration period runs at a constant rate.

Parameters:
- CODE_LEN, 2046, chips per code period (B1I); must be >= 2.
- CHIP_W, 11, width of chip index; 2^CHIP_W >= CODE_LEN.
- CAR_PHASE_W, 8, carrier phase output width (MSBs of the carrier accumulator).

Ports:
- rx_clk  input  1  system clock.
- rx_rst  input  1  asynchronous active-high reset.
- nco_start  input  1  pulse: leave IDLE, load FCWs, begin running.
- nco_stop  input  1  pulse: return to IDLE.
- tx_prn_fcw  input  32  code NCO FCW (chip rate / fclk × 2^32).
- tx_car_fcw  input  32  carrier NCO FCW (IF+Doppler / fclk × 2^32).
- nco_run  output  1  high while state is RUN.
- car_phase  output  CAR_PHASE_W  carrier accumulator bits [31:32-CAR_PHASE_W].
- code_chip_idx  output  CHIP_W  current chip, 0..CODE_LEN-1.
- code_phase_frac  output  8  code accumulator bits [31:24]; bit 7 is the half-chip flag for E/L.
- chip_stb  output  1  one-cycle pulse on each chip advance.
- rx_prn_sop  output  1  one-cycle pulse on code period wrap.

Behaviour:
- Reset (async, rx_rst=1): state IDLE; both accumulators, both active FCW registers, chip index, chip_stb, rx_prn_sop, nco_run and epoch_cnt are 0.
- States: IDLE, RUN.
  - IDLE→RUN when nco_start=1 and nco_stop=0.
  - RUN→IDLE when nco_stop=1.
  - nco_start while in RUN: ignored.
  - nco_start and nco_stop in the same cycle: stop wins, state is IDLE.
- Entering RUN (edge sampling nco_start):
  - car_fcw_act ← tx_car_fcw, prn_fcw_act ← tx_prn_fcw.
  - Accumulators and chip index cleared to 0.
  - nco_run=1 from the next cycle.
- Each RUN cycle:
  - car_acc ← car_acc + car_fcw_act, modulo 2^32.
  - {carry, code_acc} ← code_acc + prn_fcw_act, 33-bit sum.
- On carry=1:
  - chip_stb=1 registered, visible the next cycle.
  - If code_chip_idx == CODE_LEN-1: chip index ← 0 and rx_prn_sop=1 in the same cycle as chip_stb. Otherwise chip index increments by 1.
- FCW latch at epoch: in the cycle rx_prn_sop is asserted, car_fcw_act and prn_fcw_act reload from the inputs. The new rate applies from the following accumulation. Input changes at any other time have no effect.
- Pulses: chip_stb and rx_prn_sop are high for exactly one cycle per event. They never assert in IDLE.
- Leaving RUN (nco_stop sampled):
  - Next cycle: accumulators, chip index, pulses and nco_run are 0.
  - An epoch coinciding with the stop cycle is suppressed.
- Latency: the first accumulation happens in the first RUN cycle, which is one cycle after nco_start is sampled. With prn_fcw=0x80000000, the first chip_stb appears 2 cycles after nco_run rises.
- prn_fcw=0: code phase frozen, no chip_stb and no epoch. car_fcw=0: car_phase holds.
- All outputs are registered; none depend combinationally on inputs.

Optional Feature:
- Macro TRK_NCO_EPOCH_CNT_EN.
- When defined: adds output port epoch_cnt (16 bits).
  - Reset and IDLE value 0.
  - Increments by 1 in the cycle rx_prn_sop asserts; wraps 0xFFFF→0x0000.
  - Used for bit-sync/ms counting.
- When undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset mid-run: assert rx_rst asynchronously during RUN → all outputs 0 immediately with no clock edge; state IDLE after release.
- CODE_LEN=4, tx_prn_fcw=0x80000000, start → chip_stb every 2 cycles; chip index sequence 1,2,3,0; rx_prn_sop every 8 cycles coincident with index 0.
- tx_car_fcw=0x01000000, CAR_PHASE_W=8 → car_phase increments by 1 per RUN cycle and wraps 255→0 after 256 cycles.
- Change tx_prn_fcw from 0x80000000 to 0x40000000 mid-period → chip spacing stays 2 cycles until rx_prn_sop, then becomes 4 cycles.
- nco_start and nco_stop in the same cycle in IDLE → stays IDLE, nco_run=0. nco_stop on an epoch cycle → no rx_prn_sop, outputs 0 next cycle.
- With TRK_NCO_EPOCH_CNT_EN defined, preload via 65536 epochs (CODE_LEN=2, fcw=0xFFFFFFFF) → epoch_cnt wraps to 0x0000 on the 65536th rx_prn_sop.

Source files
------------

// File: rtl/trk_code_car_nco.sv
// Tracking-channel code/carrier NCO pair.
// Two 32-bit phase accumulators: the carrier accumulator feeds car_phase,
// and the code accumulator's carry steps the chip index. FCWs are sampled
// on start and on every code epoch, so each integration period runs at a
// constant rate.
// Optional: define TRK_NCO_EPOCH_CNT_EN to add the 16-bit epoch_cnt output.
module trk_code_car_nco #(
  parameter int unsigned CODE_LEN    = 2046,
  parameter int unsigned CHIP_W      = 11,
  parameter int unsigned CAR_PHASE_W = 8
) (
  input  logic                   rx_clk,
  input  logic                   rx_rst,
  input  logic                   nco_start,
  input  logic                   nco_stop,
  input  logic [31:0]            tx_prn_fcw,
  input  logic [31:0]            tx_car_fcw,
  output logic                   nco_run,
  output logic [CAR_PHASE_W-1:0] car_phase,
  output logic [CHIP_W-1:0]      code_chip_idx,
  output logic [7:0]             code_phase_frac,
  output logic                   chip_stb,
  output logic                   rx_prn_sop
`ifdef TRK_NCO_EPOCH_CNT_EN
  ,
  output logic [15:0]            epoch_cnt
`endif
);

  localparam int unsigned ACC_W    = 32;
  localparam int unsigned LAST_IDX = CODE_LEN - 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ACC_W-1:0]    car_acc_q, car_acc_d;
  logic [ACC_W-1:0]    code_acc_q, code_acc_d;
  logic [ACC_W-1:0]    car_fcw_act_q, car_fcw_act_d;
  logic [ACC_W-1:0]    prn_fcw_act_q, prn_fcw_act_d;
  logic [CHIP_W-1:0]   chip_idx_q, chip_idx_d;
  logic                chip_stb_q, chip_stb_d;
  logic                sop_q, sop_d;

  logic                start_c;
  logic                running_c;
  logic [ACC_W:0]      code_sum_c;
  logic                carry_c;
  logic                epoch_c;

  // Start is honoured only from IDLE and only when stop is not also requested.
  assign start_c   = (state_q == S_IDLE) && nco_start && !nco_stop;
  assign running_c = (state_q == S_RUN) && !nco_stop;

  // 33-bit code accumulation; the carry marks a chip advance.
  assign code_sum_c = {1'b0, code_acc_q} + {1'b0, prn_fcw_act_q};
  assign carry_c    = code_sum_c[ACC_W];
  assign epoch_c    = carry_c && (chip_idx_q == CHIP_W'(LAST_IDX));

  // State register.
  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: stop always wins, start only leaves IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_c)  state_d = S_RUN;
      S_RUN:   if (nco_stop) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: accumulate while running, clear otherwise.
  always_comb begin
    car_acc_d     = '0;
    code_acc_d    = '0;
    car_fcw_act_d = car_fcw_act_q;
    prn_fcw_act_d = prn_fcw_act_q;
    chip_idx_d    = '0;
    chip_stb_d    = 1'b0;
    sop_d         = 1'b0;
    if (running_c) begin
      car_acc_d  = car_acc_q + car_fcw_act_q;
      code_acc_d = code_sum_c[ACC_W-1:0];
      chip_stb_d = carry_c;
      sop_d      = epoch_c;
      chip_idx_d = chip_idx_q;
      if (epoch_c)      chip_idx_d = '0;
      else if (carry_c) chip_idx_d = chip_idx_q + CHIP_W'(1);
      // New rates take effect on the accumulation after the epoch edge.
      if (epoch_c) begin
        car_fcw_act_d = tx_car_fcw;
        prn_fcw_act_d = tx_prn_fcw;
      end
    end else if (start_c) begin
      car_fcw_act_d = tx_car_fcw;
      prn_fcw_act_d = tx_prn_fcw;
    end
  end

  // Datapath registers.
  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) begin
      car_acc_q     <= '0;
      code_acc_q    <= '0;
      car_fcw_act_q <= '0;
      prn_fcw_act_q <= '0;
      chip_idx_q    <= '0;
      chip_stb_q    <= 1'b0;
      sop_q         <= 1'b0;
    end else begin
      car_acc_q     <= car_acc_d;
      code_acc_q    <= code_acc_d;
      car_fcw_act_q <= car_fcw_act_d;
      prn_fcw_act_q <= prn_fcw_act_d;
      chip_idx_q    <= chip_idx_d;
      chip_stb_q    <= chip_stb_d;
      sop_q         <= sop_d;
    end
  end

  assign nco_run         = (state_q == S_RUN);
  assign car_phase       = car_acc_q[ACC_W-1 -: CAR_PHASE_W];
  assign code_chip_idx   = chip_idx_q;
  assign code_phase_frac = code_acc_q[ACC_W-1 -: 8];
  assign chip_stb        = chip_stb_q;
  assign rx_prn_sop      = sop_q;

`ifdef TRK_NCO_EPOCH_CNT_EN
  logic [15:0] epoch_cnt_q, epoch_cnt_d;

  // Epoch counter: counts code periods while running, cleared in IDLE.
  always_comb begin
    epoch_cnt_d = '0;
    if (running_c) epoch_cnt_d = epoch_cnt_q + 16'(epoch_c);
  end

  // Epoch counter register.
  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) epoch_cnt_q <= '0;
    else        epoch_cnt_q <= epoch_cnt_d;
  end

  assign epoch_cnt = epoch_cnt_q;
`endif

endmodule

// File: tb/tb_trk_code_car_nco.sv
// Directed bench for trk_code_car_nco with CODE_LEN=4.
module tb_trk_code_car_nco;

  localparam int unsigned CODE_LEN = 4;
  localparam int unsigned CHIP_W   = 2;

  logic        rx_clk = 1'b0;
  logic        rx_rst;
  logic        nco_start, nco_stop;
  logic [31:0] tx_prn_fcw, tx_car_fcw;
  logic        nco_run;
  logic [7:0]  car_phase;
  logic [1:0]  code_chip_idx;
  logic [7:0]  code_phase_frac;
  logic        chip_stb, rx_prn_sop;
`ifdef TRK_NCO_EPOCH_CNT_EN
  logic [15:0] epoch_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  trk_code_car_nco #(
    .CODE_LEN(CODE_LEN), .CHIP_W(CHIP_W), .CAR_PHASE_W(8)
  ) dut (
    .rx_clk(rx_clk), .rx_rst(rx_rst),
    .nco_start(nco_start), .nco_stop(nco_stop),
    .tx_prn_fcw(tx_prn_fcw), .tx_car_fcw(tx_car_fcw),
    .nco_run(nco_run), .car_phase(car_phase),
    .code_chip_idx(code_chip_idx), .code_phase_frac(code_phase_frac),
    .chip_stb(chip_stb), .rx_prn_sop(rx_prn_sop)
`ifdef TRK_NCO_EPOCH_CNT_EN
    , .epoch_cnt(epoch_cnt)
`endif
  );

  always #5 rx_clk = ~rx_clk;

  typedef struct {
    logic        start;
    logic        stop;
    logic [31:0] prn;
    logic [31:0] car;
    logic        run;
    logic [7:0]  ph;
    logic [1:0]  idx;
    logic [7:0]  frac;
    logic        stb;
    logic        sop;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(logic st, logic sp, logic [31:0] p, logic [31:0] c,
                              logic r, logic [7:0] ph, logic [1:0] ix,
                              logic [7:0] fr, logic sb, logic so);
    vec_t v;
    v.start = st; v.stop = sp; v.prn = p; v.car = c;
    v.run = r; v.ph = ph; v.idx = ix; v.frac = fr; v.stb = sb; v.sop = so;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input vec_t v);
    check({tag, ".nco_run"},   32'(nco_run),         32'(v.run));
    check({tag, ".car_phase"}, 32'(car_phase),       32'(v.ph));
    check({tag, ".chip_idx"},  32'(code_chip_idx),   32'(v.idx));
    check({tag, ".frac"},      32'(code_phase_frac), 32'(v.frac));
    check({tag, ".chip_stb"},  32'(chip_stb),        32'(v.stb));
    check({tag, ".prn_sop"},   32'(rx_prn_sop),      32'(v.sop));
  endtask

  localparam logic [31:0] P80 = 32'h8000_0000;
  localparam logic [31:0] P40 = 32'h4000_0000;
  localparam logic [31:0] C1  = 32'h0100_0000;
  localparam logic [31:0] C2  = 32'h0200_0000;

  initial begin
    vec_t z;
    z = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // start, accumulate, FCW change mid-period takes effect at epoch
    tv.push_back(mk(1, 0, P80, C1, 1, 8'd0,  0, 8'h00, 0, 0));
    tv.push_back(mk(0, 0, P80, C1, 1, 8'd1,  0, 8'h80, 0, 0));
    tv.push_back(mk(0, 0, P80, C1, 1, 8'd2,  1, 8'h00, 1, 0));
    tv.push_back(mk(0, 0, P80, C1, 1, 8'd3,  1, 8'h80, 0, 0));
    tv.push_back(mk(0, 0, P40, C2, 1, 8'd4,  2, 8'h00, 1, 0));
    tv.push_back(mk(0, 0, P40, C2, 1, 8'd5,  2, 8'h80, 0, 0));
    tv.push_back(mk(0, 0, P40, C2, 1, 8'd6,  3, 8'h00, 1, 0));
    tv.push_back(mk(0, 0, P40, C2, 1, 8'd7,  3, 8'h80, 0, 0));
    tv.push_back(mk(0, 0, P40, C2, 1, 8'd8,  0, 8'h00, 1, 1));
    tv.push_back(mk(0, 0, P80, C1, 1, 8'd10, 0, 8'h40, 0, 0));
    tv.push_back(mk(0, 0, P80, C1, 1, 8'd12, 0, 8'h80, 0, 0));
    tv.push_back(mk(0, 0, P80, C1, 1, 8'd14, 0, 8'hC0, 0, 0));
    tv.push_back(mk(0, 0, P80, C1, 1, 8'd16, 1, 8'h00, 1, 0));
    // stop, then start+stop together from IDLE
    tv.push_back(mk(0, 1, P80, C1, 0, 8'd0,  0, 8'h00, 0, 0));
    tv.push_back(mk(1, 1, P80, C1, 0, 8'd0,  0, 8'h00, 0, 0));
    tv.push_back(mk(0, 0, P80, C1, 0, 8'd0,  0, 8'h00, 0, 0));
    // restart and stop exactly on the epoch edge
    tv.push_back(mk(1, 0, P80, C1, 1, 8'd0,  0, 8'h00, 0, 0));
    tv.push_back(mk(0, 0, P80, C1, 1, 8'd1,  0, 8'h80, 0, 0));
    tv.push_back(mk(1, 0, P80, C1, 1, 8'd2,  1, 8'h00, 1, 0));
    tv.push_back(mk(0, 0, P80, C1, 1, 8'd3,  1, 8'h80, 0, 0));
    tv.push_back(mk(0, 0, P80, C1, 1, 8'd4,  2, 8'h00, 1, 0));
    tv.push_back(mk(0, 0, P80, C1, 1, 8'd5,  2, 8'h80, 0, 0));
    tv.push_back(mk(0, 0, P80, C1, 1, 8'd6,  3, 8'h00, 1, 0));
    tv.push_back(mk(0, 0, P80, C1, 1, 8'd7,  3, 8'h80, 0, 0));
    tv.push_back(mk(0, 1, P80, C1, 0, 8'd0,  0, 8'h00, 0, 0));
    tv.push_back(mk(0, 0, P80, C1, 0, 8'd0,  0, 8'h00, 0, 0));

    rx_rst = 1'b1; nco_start = 1'b0; nco_stop = 1'b0;
    tx_prn_fcw = '0; tx_car_fcw = '0;
    repeat (2) @(negedge rx_clk);
    check_outs("reset", z);
`ifdef TRK_NCO_EPOCH_CNT_EN
    check("reset.epoch_cnt", 32'(epoch_cnt), 0);
`endif
    rx_rst = 1'b0;
    @(negedge rx_clk);
    check_outs("post_reset", z);

    // table-driven vectors: drive at negedge, check at the following negedge
    for (int i = 0; i < tv.size(); i++) begin
      nco_start = tv[i].start; nco_stop = tv[i].stop;
      tx_prn_fcw = tv[i].prn;  tx_car_fcw = tv[i].car;
      @(posedge rx_clk);
      @(negedge rx_clk);
      check_outs($sformatf("vec%0d", i), tv[i]);
    end

    // carrier wrap with frozen code NCO
    nco_start = 1'b1; tx_prn_fcw = '0; tx_car_fcw = C1;
    @(negedge rx_clk);
    nco_start = 1'b0;
    begin
      int bad_ph = 0, bad_code = 0;
      for (int n = 1; n <= 260; n++) begin
        @(negedge rx_clk);
        if (car_phase !== 8'(n)) bad_ph++;
        if (chip_stb !== 1'b0 || rx_prn_sop !== 1'b0 ||
            code_chip_idx !== 2'd0 || code_phase_frac !== 8'h00) bad_code++;
        if (n == 255) check("car_wrap.255", 32'(car_phase), 32'd255);
        if (n == 256) check("car_wrap.0",   32'(car_phase), 32'd0);
      end
      check("car_ramp.errors",   32'(bad_ph),   0);
      check("code_frozen.errors", 32'(bad_code), 0);
    end
    nco_stop = 1'b1;
    @(negedge rx_clk);
    nco_stop = 1'b0;
    check("car_stop.run", 32'(nco_run), 0);

    // car_fcw=0 holds phase
    nco_start = 1'b1; tx_prn_fcw = P80; tx_car_fcw = '0;
    @(negedge rx_clk);
    nco_start = 1'b0;
    repeat (5) @(negedge rx_clk);
    check("car_hold.phase", 32'(car_phase), 0);
    check("car_hold.frac",  32'(code_phase_frac), 32'h80);

    // asynchronous reset during RUN
    check("pre_rst.run", 32'(nco_run), 1);
    #2 rx_rst = 1'b1;
    #1;
    check("async_rst.run",  32'(nco_run), 0);
    check("async_rst.idx",  32'(code_chip_idx), 0);
    check("async_rst.frac", 32'(code_phase_frac), 0);
    check("async_rst.stb",  32'(chip_stb), 0);
    @(negedge rx_clk);
    rx_rst = 1'b0;
    @(negedge rx_clk);
    check("after_rst.run", 32'(nco_run), 0);

`ifdef TRK_NCO_EPOCH_CNT_EN
    // fcw=all-ones: carries from edge 2, epochs at edges 5,9,13,...
    nco_start = 1'b1; tx_prn_fcw = 32'hFFFF_FFFF; tx_car_fcw = C1;
    @(negedge rx_clk);
    nco_start = 1'b0;
    repeat (41) @(negedge rx_clk);
    check("epoch_cnt.10", 32'(epoch_cnt), 32'd10);
    check("epoch_cnt.sop", 32'(rx_prn_sop), 1);
    nco_stop = 1'b1;
    @(negedge rx_clk);
    nco_stop = 1'b0;
    check("epoch_cnt.idle", 32'(epoch_cnt), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
